ddr2_read_capture: RTL and testbench

- Downstream consumer of the PHY's read-return path (`dq_i`, `dqs_i`).
- Times each read burst from the protocol engine's read-issue strobe and captures one 16-bit word per `clk` during the burst window.
- Optionally checks DQS phase and buffers words plus a last-word tag in a ring-buffer FIFO.
- The controller's read-data port drains the FIFO with a valid/ready handshake.

---
 rtl/ddr2_read_capture_pkg.sv | 26 ++
 rtl/ddr2_rdcap_fifo.sv | 62 ++++++
 rtl/ddr2_read_capture.sv | 171 +++++++++++++++++
 tb/tb_ddr2_read_capture.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_read_capture_pkg.sv
// Shared constants, types and helpers for the DDR2 read-return capture path.
package ddr2_read_capture_pkg;

    localparam int unsigned DDR2_DQ_W      = 16;
    localparam int unsigned DDR2_BL4       = 4;
    localparam int unsigned DDR2_BL8       = 8;
    localparam int unsigned DDR2_DEF_RL    = 8;
    localparam int unsigned DDR2_DEF_DEPTH = 16;
    localparam int unsigned BCNT_W         = $clog2(DDR2_BL8);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } cap_state_e;

    typedef struct packed {
        logic launch;
        logic bl8;
    } launch_t;

    // Word counter start value: the counter reaches 0 on the last word.
    function automatic logic [BCNT_W-1:0] burst_cnt_init(input logic bl8);
        return bl8 ? BCNT_W'(DDR2_BL8 - 1) : BCNT_W'(DDR2_BL4 - 1);
    endfunction

endpackage

// File: rtl/ddr2_rdcap_fifo.sv
// Ring-buffer FIFO with exact occupancy; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module ddr2_rdcap_fifo
    import ddr2_read_capture_pkg::*;
#(
    parameter int unsigned W     = DDR2_DQ_W + 1,
    parameter int unsigned DEPTH = DDR2_DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_c,
    output logic                     empty_c,
    output logic                     full_c,
    output logic                     drop_c,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_c;
    assign do_push = push_i & (~full_c | do_pop);
    assign drop_c  = push_i & full_c & ~do_pop;
    assign rdata_c = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ddr2_read_capture.sv
// Read-burst capture: launch pipeline, burst FSM and sticky error flags feeding
// a read-data FIFO. Optional DQS phase check enabled by DDR2_RDCAP_DQS_CHECK_EN.
module ddr2_read_capture
    import ddr2_read_capture_pkg::*;
#(
    parameter int unsigned RL_CYCLES = DDR2_DEF_RL,
    parameter int unsigned DEPTH     = DDR2_DEF_DEPTH,
    parameter int unsigned DQ_W      = DDR2_DQ_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ready,
    input  logic                   rd_issue,
    input  logic                   rd_bl8,
    input  logic [DQ_W-1:0]        dq_i,
    input  logic [1:0]             dqs_i,
    output logic [DQ_W-1:0]        rd_data,
    output logic                   rd_last,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   overlap_err,
    output logic                   dqs_err,
    input  logic                   clr_err
);

    // RL-1 register stages; the burst state register supplies the final cycle
    // so the first word is captured RL_CYCLES edges after the issue edge.
    launch_t [RL_CYCLES-2:0] pipe_q;
    logic                    launch_c;
    logic                    bl8_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= '{launch: rd_issue & ready, bl8: rd_bl8};
            for (int unsigned i = 1; i < RL_CYCLES - 1; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign launch_c = pipe_q[RL_CYCLES-2].launch;
    assign bl8_c    = pipe_q[RL_CYCLES-2].bl8;

    cap_state_e        state_q, state_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic              push_c;
    logic              last_c;
    logic              overlap_set_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        push_c        = 1'b0;
        last_c        = 1'b0;
        overlap_set_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch_c) begin
                    state_d = ST_BURST;
                    cnt_d   = burst_cnt_init(bl8_c);
                end
            end
            ST_BURST: begin
                push_c = 1'b1;
                last_c = (cnt_q == '0);
                if (cnt_q == '0) begin
                    // A launch on the last word chains the next burst seamlessly.
                    if (launch_c) begin
                        cnt_d = burst_cnt_init(bl8_c);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d         = cnt_q - BCNT_W'(1);
                    overlap_set_c = launch_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [DQ_W:0] fifo_rdata_c;
    logic          fifo_empty_c;
    logic          fifo_full_unused;
    logic          fifo_drop_c;

    ddr2_rdcap_fifo #(
        .W     (DQ_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .wdata_i ({last_c, dq_i}),
        .pop_i   (rd_ready),
        .rdata_c (fifo_rdata_c),
        .empty_c (fifo_empty_c),
        .full_c  (fifo_full_unused),
        .drop_c  (fifo_drop_c),
        .count_o (fifo_count)
    );

    assign rd_data  = fifo_rdata_c[DQ_W-1:0];
    assign rd_last  = fifo_rdata_c[DQ_W];
    assign rd_valid = ~fifo_empty_c;

    logic overflow_q;
    logic overlap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            overlap_q  <= 1'b0;
        end else begin
            overflow_q <= fifo_drop_c | (overflow_q & ~clr_err);
            overlap_q  <= overlap_set_c | (overlap_q & ~clr_err);
        end
    end

    assign overflow    = overflow_q;
    assign overlap_err = overlap_q;

`ifdef DDR2_RDCAP_DQS_CHECK_EN
    // Expected strobe: 11 on a burst's first word, then alternating 00/11.
    logic [1:0] dqs_exp_q, dqs_exp_d;
    logic       dqs_set_c;
    logic       dqs_err_q;

    always_comb begin
        dqs_exp_d = dqs_exp_q;
        dqs_set_c = push_c && (dqs_i != dqs_exp_q);
        if (push_c) begin
            dqs_exp_d = ~dqs_exp_q;
        end
        if (launch_c && (state_q == ST_IDLE || cnt_q == '0)) begin
            dqs_exp_d = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dqs_exp_q <= 2'b11;
            dqs_err_q <= 1'b0;
        end else begin
            dqs_exp_q <= dqs_exp_d;
            dqs_err_q <= dqs_set_c | (dqs_err_q & ~clr_err);
        end
    end

    assign dqs_err = dqs_err_q;
`else
    logic unused_dqs;
    assign unused_dqs = ^dqs_i;
    assign dqs_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_read_capture.sv
// Self-checking bench for ddr2_read_capture: directed scenarios plus a random
// run compared cycle by cycle against a burst-schedule / queue reference model.
module tb_ddr2_read_capture;

    localparam int RL    = 8;
    localparam int DEPTH = 16;
    localparam int DQ_W  = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef DDR2_RDCAP_DQS_CHECK_EN
    localparam bit DQS_CHK = 1'b1;
`else
    localparam bit DQS_CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ready = 1'b1;
    logic            rd_issue = 1'b0;
    logic            rd_bl8 = 1'b0;
    logic [DQ_W-1:0] dq_i = '0;
    logic [1:0]      dqs_i = '0;
    logic [DQ_W-1:0] rd_data;
    logic            rd_last;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic [CW-1:0]   fifo_count;
    logic            overflow;
    logic            overlap_err;
    logic            dqs_err;
    logic            clr_err = 1'b0;

    always #5 clk = ~clk;

    ddr2_read_capture #(.RL_CYCLES(RL), .DEPTH(DEPTH), .DQ_W(DQ_W)) dut (
        .clk(clk), .reset(reset), .ready(ready), .rd_issue(rd_issue), .rd_bl8(rd_bl8),
        .dq_i(dq_i), .dqs_i(dqs_i), .rd_data(rd_data), .rd_last(rd_last),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .fifo_count(fifo_count),
        .overflow(overflow), .overlap_err(overlap_err), .dqs_err(dqs_err), .clr_err(clr_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: scheduled burst windows plus a queue of stored words.
    typedef struct { int start; int stop; } burst_t;
    burst_t          bursts[$];
    int              ov_edges[$];
    logic [DQ_W:0]   mq[$];
    int              busy_end = -1000;
    logic            m_ovf = 1'b0;
    logic            m_ovl = 1'b0;
    logic            m_dqs = 1'b0;

    function automatic void model_edge();
        bit cap, lst, pop, drop, ov_set, dqs_set;
        int idx, L, bl;
        if (reset) begin
            bursts.delete(); ov_edges.delete(); mq.delete();
            busy_end = -1000; m_ovf = 0; m_ovl = 0; m_dqs = 0;
            return;
        end
        cap = 0; lst = 0; idx = 0; ov_set = 0;
        while (bursts.size() > 0 && bursts[0].stop < cyc) void'(bursts.pop_front());
        if (bursts.size() > 0 && bursts[0].start <= cyc) begin
            cap = 1; lst = (bursts[0].stop == cyc); idx = cyc - bursts[0].start;
        end
        while (ov_edges.size() > 0 && ov_edges[0] <= cyc) begin
            if (ov_edges[0] == cyc) ov_set = 1;
            void'(ov_edges.pop_front());
        end
        pop  = (mq.size() > 0) && rd_ready;
        drop = cap && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (cap && !drop) mq.push_back({lst, dq_i});
        dqs_set = DQS_CHK && cap && (dqs_i != ((idx % 2 == 0) ? 2'b11 : 2'b00));
        m_ovf = drop    | (m_ovf & ~clr_err);
        m_ovl = ov_set  | (m_ovl & ~clr_err);
        m_dqs = dqs_set | (m_dqs & ~clr_err);
        if (rd_issue && ready) begin
            L  = cyc + RL;
            bl = rd_bl8 ? 8 : 4;
            if (L <= busy_end) ov_edges.push_back(L - 1);
            else begin
                bursts.push_back('{L, L + bl - 1});
                busy_end = L + bl - 1;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; rd_issue = 0; clr_err = 0; rd_ready = 0; ready = 1;
        step(); step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) step();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h want 0", rd_valid); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_data: got %0h want 0", rd_data); end
        total++; if (rd_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %0h want 0", rd_last); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if ({overflow, overlap_err, dqs_err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {overflow, overlap_err, dqs_err});
        end
        reset = 0;
    endtask

    task automatic test_single_bl4();
        do_reset();
        rd_issue = 1; rd_bl8 = 0; dq_i = 16'($urandom);
        step();
        rd_issue = 0;
        for (int k = 1; k <= RL + 5; k++) begin
            dq_i = (k >= RL && k < RL + 4) ? 16'(32'hA0A0 + k - RL) : 16'($urandom);
            step();
            if (k == RL - 1) begin
                total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL bl4_valid_early: got %0h want 0", rd_valid); end
            end
            if (k == RL) begin
                total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL bl4_valid_rise: got %0h want 1", rd_valid); end
            end
        end
        total++; if (fifo_count !== CW'(4)) begin bad++; $display("FAIL bl4_count: got %0d want 4", fifo_count); end
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_data !== 16'(32'hA0A0 + i)) begin
                bad++; $display("FAIL bl4_data%0d: got %0h want %0h", i, rd_data, 16'(32'hA0A0 + i));
            end
            total++; if (rd_last !== (i == 3)) begin bad++; $display("FAIL bl4_last%0d: got %0h want %0h", i, rd_last, (i == 3)); end
            step();
        end
        rd_ready = 0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL bl4_drained: got %0h want 0", rd_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rd_bl8 = 1;
        for (int k = 0; k < RL + 18; k++) begin
            rd_issue = (k == 0 || k == 8);
            dq_i = 16'(32'h1000 + k);
            step();
        end
        rd_issue = 0;
        total++; if (fifo_count !== CW'(16)) begin bad++; $display("FAIL b2b_count: got %0d want 16", fifo_count); end
        total++; if (overlap_err !== 1'b0) begin bad++; $display("FAIL b2b_overlap: got %0h want 0", overlap_err); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow: got %0h want 0", overflow); end
        rd_ready = 1;
        for (int j = 0; j < 16; j++) begin
            total++; if ({rd_last, rd_data} !== {(j == 7 || j == 15), 16'(32'h1000 + RL + j)}) begin
                bad++; $display("FAIL b2b_word%0d: got %0h want %0h", j, {rd_last, rd_data},
                                {(j == 7 || j == 15), 16'(32'h1000 + RL + j)});
            end
            step();
        end
        rd_ready = 0;
    endtask

    task automatic test_overlap();
        do_reset();
        rd_bl8 = 1;
        for (int k = 0; k < RL + 14; k++) begin
            rd_issue = (k == 0 || k == 2);
            dq_i = 16'(32'h2000 + k);
            step();
        end
        rd_issue = 0;
        total++; if (overlap_err !== 1'b1) begin bad++; $display("FAIL ovl_flag: got %0h want 1", overlap_err); end
        total++; if (fifo_count !== CW'(8)) begin bad++; $display("FAIL ovl_count: got %0d want 8", fifo_count); end
        clr_err = 1; step(); clr_err = 0;
        total++; if (overlap_err !== 1'b0) begin bad++; $display("FAIL ovl_clear: got %0h want 0", overlap_err); end
    endtask

    task automatic test_overflow();
        do_reset();
        rd_bl8 = 1;
        for (int k = 0; k < RL + 28; k++) begin
            rd_issue = (k == 0 || k == 8 || k == 16);
            dq_i = 16'(32'h3000 + k);
            step();
        end
        rd_issue = 0;
        total++; if (fifo_count !== CW'(16)) begin bad++; $display("FAIL ovf_count: got %0d want 16", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0h want 1", overflow); end
        total++; if (rd_data !== 16'(32'h3000 + RL)) begin bad++; $display("FAIL ovf_head: got %0h want %0h", rd_data, 16'(32'h3000 + RL)); end
        // Second pass: consumer pops exactly while the third burst arrives at full.
        do_reset();
        rd_bl8 = 1;
        for (int k = 0; k < RL + 28; k++) begin
            rd_issue = (k == 0 || k == 8 || k == 16);
            rd_ready = (k >= RL + 16 && k < RL + 24);
            dq_i = 16'(32'h4000 + k);
            step();
        end
        rd_issue = 0; rd_ready = 0;
        total++; if (fifo_count !== CW'(16)) begin bad++; $display("FAIL keep_count: got %0d want 16", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL keep_flag: got %0h want 0", overflow); end
        total++; if (rd_data !== 16'(32'h4000 + RL + 8)) begin bad++; $display("FAIL keep_head: got %0h want %0h", rd_data, 16'(32'h4000 + RL + 8)); end
        rd_ready = 1;
        for (int j = 0; j < 16; j++) begin
            total++; if ({rd_last, rd_data} !== mq[0]) begin bad++; $display("FAIL keep_word%0d: got %0h want %0h", j, {rd_last, rd_data}, mq[0]); end
            step();
        end
        rd_ready = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rd_bl8 = 1;
        for (int k = 0; k < RL + 2; k++) begin
            rd_issue = (k == 0);
            dq_i = 16'($urandom);
            step();
        end
        total++; if (fifo_count !== CW'(2)) begin bad++; $display("FAIL rstmid_pre: got %0d want 2", fifo_count); end
        reset = 1; step(); reset = 0;
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0h want 0", rd_valid); end
        repeat (10) begin dq_i = 16'($urandom); step(); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL rstmid_after: got %0d want 0", fifo_count); end
    endtask

    task automatic test_dqs();
        int i;
        do_reset();
        rd_bl8 = 0;
        for (int k = 0; k < RL + 6; k++) begin
            rd_issue = (k == 0);
            dq_i = 16'($urandom);
            i = k - RL;
            if (k >= RL && k < RL + 4) dqs_i = (i == 2) ? 2'b10 : ((i % 2 == 0) ? 2'b11 : 2'b00);
            else dqs_i = 2'b00;
            step();
        end
        rd_issue = 0;
        total++; if (dqs_err !== DQS_CHK) begin bad++; $display("FAIL dqs_flag: got %0h want %0h", dqs_err, DQS_CHK); end
        total++; if (fifo_count !== CW'(4)) begin bad++; $display("FAIL dqs_count: got %0d want 4", fifo_count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            ready    = ($urandom_range(0, 9) != 0);
            rd_issue = ($urandom_range(0, 4) == 0);
            rd_bl8   = 1'($urandom);
            rd_ready = ($urandom_range(0, 9) < 6);
            clr_err  = ($urandom_range(0, 19) == 0);
            dq_i     = 16'($urandom);
            dqs_i    = 2'($urandom);
            step();
            total++; if (rd_valid !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_valid@%0d: got %0h want %0h", cyc, rd_valid, (mq.size() > 0)); end
            total++; if (fifo_count !== CW'(mq.size())) begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, fifo_count, mq.size()); end
            if (mq.size() > 0) begin
                total++; if ({rd_last, rd_data} !== mq[0]) begin bad++; $display("FAIL rnd_head@%0d: got %0h want %0h", cyc, {rd_last, rd_data}, mq[0]); end
            end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_overflow@%0d: got %0h want %0h", cyc, overflow, m_ovf); end
            total++; if (overlap_err !== m_ovl) begin bad++; $display("FAIL rnd_overlap@%0d: got %0h want %0h", cyc, overlap_err, m_ovl); end
            total++; if (dqs_err !== m_dqs) begin bad++; $display("FAIL rnd_dqs@%0d: got %0h want %0h", cyc, dqs_err, m_dqs); end
        end
        reset = 0; rd_issue = 0; clr_err = 0; ready = 1;
    endtask

    initial begin
        test_reset();
        test_single_bl4();
        test_back_to_back();
        test_overlap();
        test_overflow();
        test_reset_mid();
        test_dqs();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
